// File: rtl/card_grid_renderer.sv
// Card-grid pixel renderer: maps the raster position onto a ROWS x COLS card grid, fetches
// card state from a synchronous RAM, and paints cards, glyphs and a blinking cursor frame.
module card_grid_renderer #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int CARD_W       = 64,
    parameter int GAP          = 10,
    parameter int ORIGIN_X     = 20,
    parameter int ORIGIN_Y     = 20,
    parameter int CUR_W        = 5,
    parameter int BLINK_FRAMES = 16,
    localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int GW = (CARD_W > 1) ? $clog2(CARD_W) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        CounterX,
    input  logic [9:0]        CounterY,
    input  logic              inDisplayArea,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic              hs_out,
    output logic              vs_out,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic              blink_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [5:0]        rd_data,
    output logic [3:0]        glyph_digit,
    output logic [GW-1:0]     glyph_row,
    input  logic [CARD_W-1:0] glyph_line,
    output logic [AW-1:0]     cursor_addr,
    output logic [2:0]        rgb
);
    localparam int PITCH = CARD_W + GAP;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [10:0]    x_s, y_s, cur_x_s, cur_y_s;
    logic           col_hit_s, row_hit_s, in_outer_s, in_inner_s, cur_hit_s;
    logic [3:0]     col_idx_s, row_idx_s;
    logic [GW-1:0]  x_off_s, y_off_s, gidx_s;
    logic [RW-1:0]  row_r, row_nxt_s;
    logic [CW-1:0]  col_r, col_nxt_s;
    logic           armed_r, frame_tick_s, blink_phase_r, cur_vis_s, glyph_bit_s;
    logic [BW-1:0]  blink_cnt_r;
    logic           hit1_r, cur1_r, disp1_r, hs1_r, vs1_r;
    logic [GW-1:0]  xoff1_r, grow1_r, xoff2_r;
    logic           hit2_r, cur2_r, disp2_r, hs2_r, vs2_r;
    logic [2:0]     pix_s;

    assign x_s = {1'b0, CounterX};
    assign y_s = {1'b0, CounterY};

    // Column and row span decode; spans never overlap so at most one of each matches.
    always_comb begin
        col_hit_s = 1'b0;
        col_idx_s = 4'd0;
        x_off_s   = {GW{1'b0}};
        row_hit_s = 1'b0;
        row_idx_s = 4'd0;
        y_off_s   = {GW{1'b0}};
        for (int c = 0; c < COLS; c++) begin
            if ((x_s >= 11'(ORIGIN_X + c * PITCH)) && (x_s < 11'(ORIGIN_X + c * PITCH + CARD_W))) begin
                col_hit_s = 1'b1;
                col_idx_s = 4'(c);
                x_off_s   = GW'(x_s - 11'(ORIGIN_X + c * PITCH));
            end else begin
                col_hit_s = col_hit_s;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if ((y_s >= 11'(ORIGIN_Y + r * PITCH)) && (y_s < 11'(ORIGIN_Y + r * PITCH + CARD_W))) begin
                row_hit_s = 1'b1;
                row_idx_s = 4'(r);
                y_off_s   = GW'(y_s - 11'(ORIGIN_Y + r * PITCH));
            end else begin
                row_hit_s = row_hit_s;
            end
        end
    end

    // Cursor ring: the lower bound adds CUR_W to the pixel rather than subtracting from the card edge.
    assign cur_x_s    = 11'(ORIGIN_X) + 11'(col_r) * 11'(PITCH);
    assign cur_y_s    = 11'(ORIGIN_Y) + 11'(row_r) * 11'(PITCH);
    assign in_outer_s = (x_s + 11'(CUR_W) >= cur_x_s) && (x_s < cur_x_s + 11'(CARD_W + CUR_W)) &&
                        (y_s + 11'(CUR_W) >= cur_y_s) && (y_s < cur_y_s + 11'(CARD_W + CUR_W));
    assign in_inner_s = (x_s >= cur_x_s) && (x_s < cur_x_s + 11'(CARD_W)) &&
                        (y_s >= cur_y_s) && (y_s < cur_y_s + 11'(CARD_W));
    assign cur_hit_s  = in_outer_s & ~in_inner_s;

    // Next cursor position: wraps at both ends; a real vertical move blocks horizontal motion.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (!armed_r) begin
            row_nxt_s = row_r;
        end else if (up && !down) begin
            row_nxt_s = (row_r == {RW{1'b0}}) ? RW'(ROWS - 1) : row_r - RW'(1);
        end else if (down && !up) begin
            row_nxt_s = (row_r == RW'(ROWS - 1)) ? {RW{1'b0}} : row_r + RW'(1);
        end else if (left && !right) begin
            col_nxt_s = (col_r == {CW{1'b0}}) ? CW'(COLS - 1) : col_r - CW'(1);
        end else if (right && !left) begin
            col_nxt_s = (col_r == CW'(COLS - 1)) ? {CW{1'b0}} : col_r + CW'(1);
        end else begin
            col_nxt_s = col_r;
        end
    end

    // Cursor state; armed_r drops move pulses on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_r     <= 1'b0;
            row_r       <= {RW{1'b0}};
            col_r       <= {CW{1'b0}};
            cursor_addr <= {AW{1'b0}};
        end else begin
            armed_r     <= 1'b1;
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            cursor_addr <= AW'(int'(row_nxt_s) * COLS + int'(col_nxt_s));
        end
    end

    assign frame_tick_s = (CounterX == 10'd0) && (CounterY == 10'd0);
    assign cur_vis_s    = ~blink_en | blink_phase_r;

    // Blink timer keeps counting frames even while blinking is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (frame_tick_s) begin
            if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_r   <= {BW{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // S1 decode and S2 wait-for-RAM registers; glyph_row leaves from S2 so it aligns with rd_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1_r <= 1'b0; cur1_r <= 1'b0; disp1_r <= 1'b0; hs1_r <= 1'b0; vs1_r <= 1'b0;
            xoff1_r <= {GW{1'b0}}; grow1_r <= {GW{1'b0}}; rd_addr <= {AW{1'b0}};
            hit2_r <= 1'b0; cur2_r <= 1'b0; disp2_r <= 1'b0; hs2_r <= 1'b0; vs2_r <= 1'b0;
            xoff2_r <= {GW{1'b0}}; glyph_row <= {GW{1'b0}};
        end else begin
            hit1_r  <= col_hit_s & row_hit_s;
            rd_addr <= (col_hit_s & row_hit_s) ? AW'(int'(row_idx_s) * COLS + int'(col_idx_s)) : rd_addr;
            xoff1_r <= x_off_s;
            grow1_r <= y_off_s;
            cur1_r  <= cur_hit_s;
            disp1_r <= inDisplayArea;
            hs1_r   <= hs_in;
            vs1_r   <= vs_in;
            hit2_r    <= hit1_r;
            xoff2_r   <= xoff1_r;
            glyph_row <= grow1_r;
            cur2_r    <= cur1_r;
            disp2_r   <= disp1_r;
            hs2_r     <= hs1_r;
            vs2_r     <= vs1_r;
        end
    end

    assign glyph_digit = rd_data[3:0];

    // Colour selection; card content outranks the cursor frame.
    always_comb begin
        gidx_s      = GW'(CARD_W - 1) - xoff2_r;
        glyph_bit_s = glyph_line[gidx_s];
        if (!disp2_r) begin
            pix_s = 3'b000;
        end else if (hit2_r) begin
            if (rd_data[5]) begin
                pix_s = 3'b000;
            end else if (rd_data[4]) begin
                pix_s = 3'b010;
            end else begin
                pix_s = glyph_bit_s ? 3'b111 : 3'b100;
            end
        end else if (cur2_r && cur_vis_s) begin
            pix_s = 3'b001;
        end else begin
            pix_s = 3'b000;
        end
    end

    // S3 output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb    <= 3'b000;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            rgb    <= pix_s;
            hs_out <= hs2_r;
            vs_out <= vs2_r;
        end
    end
endmodule

// File: doc/card_grid_renderer.md
CARD_GRID_RENDERER -- requirements
Module: card_grid_renderer

Interface
REQ-001 Parameter ROWS, default 4, number of card rows (1..16).
REQ-002 Parameter COLS, default 4, number of card columns (1..16).
REQ-003 Parameter CARD_W, default 64, card edge in pixels; also glyph line width.
REQ-004 Parameter GAP, default 10, pixels between adjacent cards.
REQ-005 Parameter ORIGIN_X / ORIGIN_Y, default 20 / 20, top-left pixel of card (0,0).
REQ-006 Parameter CUR_W, default 5, cursor frame thickness in pixels.
REQ-007 Parameter BLINK_FRAMES, default 16, frames per cursor blink phase.
REQ-008 Derived AW = clog2(ROWS*COLS), minimum 1; GW = clog2(CARD_W).
REQ-009 Ports, one per line: clk  in  1  pixel clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-010 CounterX  in  10  current pixel column; CounterY  in  10  current pixel row; inDisplayArea  in  1  visible-region flag.
REQ-011 hs_in / vs_in  in  1 each  raw syncs; hs_out / vs_out  out  1 each  syncs delayed to match rgb.
REQ-012 up, down, left, right  in  1 each  single-cycle debounced move pulses; blink_en  in  1  enable cursor blinking.
REQ-013 rd_addr  out  AW  sync card-RAM read address; rd_data  in  6  RAM word, valid 1 cycle after rd_addr ([5] removed, [4] face-down, [3:0] value).
REQ-014 glyph_digit  out  4  value to glyph ROM; glyph_row  out  GW  line within card; glyph_line  in  CARD_W  combinational ROM return, bit CARD_W-1 = leftmost pixel.
REQ-015 cursor_addr  out  AW  row*COLS+col of cursor; rgb  out  3  {r,g,b} pixel.

Function
REQ-016 Card (r,c) occupies X in [ORIGIN_X+c*(CARD_W+GAP), +CARD_W), Y likewise with r; all compares at 11-bit width, no overflow.
REQ-017 Cursor frame: CUR_W-thick ring surrounding cursor card, outer box extending CUR_W beyond card on each side.
REQ-018 Pipeline, 3 stages: S1 registers decoded hit, card index (rd_addr), in-card x offset, glyph_row, cursor-hit, display flag, syncs; S2 registers S1 while RAM responds; S3 registers rgb, hs_out, vs_out.
REQ-019 Latency: rgb, hs_out, vs_out reflect the coordinate/sync presented exactly 3 clk edges earlier.
REQ-020 glyph_digit = rd_data[3:0] combinationally in S2; glyph_line sampled in S2 at bit CARD_W-1-xoffset.
REQ-021 Colour priority at S3: not display -> 000; card hit and removed -> 000; card hit face-down -> 010; card hit face-up -> glyph bit ? 111 : 100; cursor hit and visible -> 001; else 000.
REQ-022 rd_addr holds its last value when no card is hit.
REQ-023 Cursor moves once per pulse: down -> row+1, up -> row-1, right -> col+1, left -> col-1, wrapping at 0 and ROWS-1 / COLS-1.
REQ-024 Simultaneous up and down: no row move; simultaneous left and right: no col move; a valid vertical move has priority and suppresses horizontal in the same cycle.
REQ-025 cursor_addr updates the cycle after the move pulse; rendering uses the new cursor from the following pixel.
REQ-026 Frame tick when CounterX==0 and CounterY==0; blink frame counter counts ticks 0..BLINK_FRAMES-1 and toggles blink_phase on wrap.
REQ-027 Cursor visible = ~blink_en | blink_phase; blink_en falling leaves counter running.

Reset
REQ-028 reset_n low asynchronously clears all pipeline registers, rgb=000, hs_out=vs_out=0, rd_addr=0, cursor row=col=0, cursor_addr=0, blink counter=0, blink_phase=1.
REQ-029 Move pulses in the cycle reset_n deasserts are ignored; reset mid-frame resumes correct output after 3 cycles with no other recovery.

Verification
REQ-030 Defaults; present (20,20) with rd_data=6'b000101, glyph_line MSB=1 -> rgb=111 exactly 3 cycles later, rd_addr=0 after 1.
REQ-031 Defaults; coordinate (94,20) -> rd_addr=1; rd_data=6'b010000 -> rgb=010; rd_data=6'b100000 -> rgb=000.
REQ-032 Cursor at (0,0), one up pulse then one left pulse -> cursor_addr=12 then 15; up+down together -> unchanged.
REQ-033 Cursor (0,0), pixel (16,16), blink_en=0 -> rgb=001; blink_en=1 -> rgb alternates 001/000 every 16 frame ticks.
REQ-034 ROWS=3, COLS=5: 5 right pulses return col to 0; 3 down pulses return row to 0; cursor_addr for (2,4)=14.
REQ-035 Assert reset_n low mid-line with cursor at 9 -> rgb=000 and cursor_addr=0 immediately, before next clk edge.
